// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader driving the instruction-memory write port
// Header is a 16-bit little-endian word count, followed by little-endian 32-bit words.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error
);

  localparam logic [16:0] CAP = 17'(2**ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state, state_nx;
  logic [7:0]            count_lo;
  logic [15:0]           words_left;
  logic [1:0]            byte_cnt;
  logic [23:0]           word;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  accept;
  logic                  restart;
  logic [15:0]           full_count;

  assign accept     = in_valid & in_ready;
  assign restart    = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));
  assign full_count = {in_data, count_lo};

  // Status outputs depend on state alone so they settle the same cycle the FSM moves.
  assign in_ready  = (state == S_LEN_LO) | (state == S_LEN_HI) | (state == S_DATA);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERROR);
  assign core_hold = (state != S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_nx = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) state_nx = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) begin
          if (full_count == 16'd0)              state_nx = S_DONE;
          else if ({1'b0, full_count} > CAP)    state_nx = S_ERROR;
          else                                  state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (byte_cnt == 2'd3) && (words_left == 16'd1)) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_lo   <= '0;
      words_left <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      word_idx   <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        count_lo   <= '0;
        words_left <= '0;
        byte_cnt   <= '0;
        word_idx   <= '0;
      end else if (accept) begin
        case (state)
          S_LEN_LO: count_lo <= in_data;
          S_LEN_HI: words_left <= full_count;
          S_DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: word[7:0]   <= in_data;
              2'd1: word[15:8]  <= in_data;
              2'd2: word[23:16] <= in_data;
              default: begin
                mem_wdata  <= {in_data, word};
                mem_addr   <= word_idx;
                mem_we     <= 1'b1;
                word_idx   <= word_idx + 1'b1;
                words_left <= words_left - 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
// Writes seen on mem_we are logged at the falling edge and compared with hand-computed images.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  int n_assert = 0;
  int n_fail   = 0;
  int we_long  = 0;
  logic prev_we = 1'b0;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic        dn;
    logic        hold;
  } wr_t;
  wr_t wq[$];

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      wq.push_back('{a: mem_addr, d: mem_wdata, dn: done, hold: core_hold});
      if (prev_we) we_long++;
    end
    prev_we = reset_n & mem_we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1;
        break;
      end
    end
    if (!ok) check("byte_timeout", 0, 1);
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[7:0], gap);
    send_byte(w[15:8], gap);
    send_byte(w[23:16], gap);
    send_byte(w[31:24], gap);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_two_word_log(input string pfx);
    check({pfx, "_nwrites"}, wq.size(), 2);
    if (wq.size() == 2) begin
      check({pfx, "_addr0"}, wq[0].a, 8'h00);
      check({pfx, "_data0"}, wq[0].d, 32'h00A00513);
      check({pfx, "_addr1"}, wq[1].a, 8'h01);
      check({pfx, "_data1"}, wq[1].d, 32'h00100593);
      check({pfx, "_done_at_w1"}, wq[1].dn, 1);
      check({pfx, "_hold_at_w1"}, wq[1].hold, 0);
      check({pfx, "_hold_at_w0"}, wq[0].hold, 1);
    end
    check({pfx, "_we_width"}, we_long, 0);
  endtask

  initial begin
    int nbad;
    logic [31:0] w;

    // T1 reset
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_core_hold", core_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    idle_cycles(2);
    check("idle_in_ready", in_ready, 0);
    check("idle_hold", core_hold, 1);

    // T2 two words, continuous stream
    wq.delete(); we_long = 0;
    pulse_start();
    check("t2_ready_after_start", in_ready, 1);
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(32'h00A00513, 0);
    send_word(32'h00100593, 0);
    in_valid = 1'b0;
    check("t2_done_with_last_we", done, 1);
    check("t2_we_last", mem_we, 1);
    idle_cycles(3);
    check_two_word_log("t2");
    check("t2_done", done, 1);
    check("t2_hold", core_hold, 0);
    check("t2_ready", in_ready, 0);
    check("t2_we_idle", mem_we, 0);
    check("t2_addr_hold", mem_addr, 8'h01);
    check("t2_wdata_hold", mem_wdata, 32'h00100593);

    // T3 stalled stream with an ignored start mid-load
    wq.delete(); we_long = 0;
    pulse_start();
    check("t3_done_cleared", done, 0);
    check("t3_hold_set", core_hold, 1);
    send_byte(8'h02, 3); send_byte(8'h00, 3);
    pulse_start();
    send_word(32'h00A00513, 3);
    send_word(32'h00100593, 3);
    idle_cycles(3);
    check_two_word_log("t3");
    check("t3_done", done, 1);

    // T4 overflow then recovery
    wq.delete();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h01, 0);
    idle_cycles(3);
    check("t4_error", error, 1);
    check("t4_ready", in_ready, 0);
    check("t4_hold", core_hold, 1);
    check("t4_done", done, 0);
    check("t4_nwrites", wq.size(), 0);
    pulse_start();
    check("t4_error_cleared", error, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    idle_cycles(2);
    check("t4_recover_done", done, 1);
    check("t4_recover_error", error, 0);

    // T5 zero count from DONE
    wq.delete();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    idle_cycles(2);
    check("t5_done", done, 1);
    check("t5_hold", core_hold, 0);
    check("t5_nwrites", wq.size(), 0);

    // T6 abort mid-word, then full-capacity image
    wq.delete(); we_long = 0;
    pulse_start();
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    reset_n = 1'b0;
    #1;
    check("t6_abort_ready", in_ready, 0);
    check("t6_abort_hold", core_hold, 1);
    check("t6_abort_done", done, 0);
    in_valid = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    idle_cycles(3);
    check("t6_abort_nwrites", wq.size(), 0);
    check("t6_abort_idle_ready", in_ready, 0);
    check("t6_abort_addr", mem_addr, 0);

    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    for (int i = 0; i < 256; i++) begin
      w = {8'hC3, 8'(i), ~8'(i), 8'(i)};
      send_word(w, 0);
    end
    idle_cycles(3);
    check("t6_nwrites", wq.size(), 256);
    nbad = 0;
    for (int i = 0; i < wq.size() && i < 256; i++) begin
      w = {8'hC3, 8'(i), ~8'(i), 8'(i)};
      if (wq[i].a !== 8'(i) || wq[i].d !== w) nbad++;
    end
    check("t6_image_bad_entries", nbad, 0);
    if (wq.size() == 256) begin
      check("t6_last_addr", wq[255].a, 8'hFF);
      check("t6_last_done", wq[255].dn, 1);
    end
    check("t6_done", done, 1);
    check("t6_error", error, 0);
    check("t6_we_width", we_long, 0);
    check("t6_addr_hold", mem_addr, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
